// File: rtl/nl2_cln_fifo_drain_if.sv
// nl2_cln_fifo_drain_if: FIFO head/pop and output valid/ready bundle for the drain block
interface nl2_cln_fifo_drain_if #(parameter int WIDTH = 1);
    logic             fifo_head_valid;
    logic [WIDTH-1:0] fifo_head_data;
    logic             pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    modport master (input fifo_head_valid, fifo_head_data, out_ready, output pop, out_valid, out_data);
    modport slave (output fifo_head_valid, fifo_head_data, out_ready, input pop, out_valid, out_data);
endinterface

// File: rtl/nl2_cln_fifo_drain.sv
// nl2_cln_fifo_drain: pops a head-valid FIFO into a 2-entry skid buffer with a flush sequence; NL2_CLN_FIFO_DRAIN_CNT_EN adds drop_cnt
module nl2_cln_fifo_drain #(parameter int WIDTH = 1) (
    input  logic clk,
    input  logic rst_a,
    nl2_cln_fifo_drain_if.master bus,
    input  logic flush_req,
    output logic flush_busy,
    output logic flush_done
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2;
    logic [1:0] state_q, state_d, cnt_q, cnt_d, idx;
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic legal, run, xfer;
    assign legal = state_q != 2'd3 && cnt_q != 2'd3;
    assign run = legal && state_q == RUN;
    assign flush_busy = state_q == FLUSH;
    assign flush_done = state_q == DONE;
    assign bus.out_valid = run && cnt_q != 2'd0;
    assign bus.out_data = e0_q;
    // pop looks only at registered state and head_valid, never at out_ready
    assign bus.pop = !rst_a && bus.fifo_head_valid && (run ? cnt_q < 2'd2 : flush_busy);
    assign xfer = bus.out_valid && bus.out_ready;
    // next state: popped data lands behind whatever survives this cycle's transfer
    always_comb begin
        idx = cnt_q - {1'b0, xfer};
        state_d = !legal ? RUN : run ? (flush_req ? FLUSH : RUN) : flush_busy ? (bus.fifo_head_valid ? FLUSH : DONE) : RUN;
        cnt_d = (run && !flush_req) ? cnt_q + {1'b0, bus.pop} - {1'b0, xfer} : 2'd0;
        e0_d = (run && bus.pop && idx == 2'd0) ? bus.fifo_head_data : xfer ? e1_q : e0_q;
        e1_d = (run && bus.pop && idx == 2'd1) ? bus.fifo_head_data : e1_q;
    end
    // state and buffer registers
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= RUN;
            cnt_q <= 2'd0;
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            e0_q <= e0_d;
            e1_q <= e1_d;
        end
    end
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;
    // a new flush restarts the tally with the entries it throws out of the buffer (including this cycle's pop)
    always_comb begin
        drop_sum = (run && flush_req) ? {15'd0, idx} + {16'd0, bus.pop}
                                      : {1'b0, drop_q} + {16'd0, flush_busy && bus.pop};
    end
    // saturating discard counter
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) drop_q <= 16'd0;
        else drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_nl2_cln_fifo_drain.sv
// tb_nl2_cln_fifo_drain: directed bench with a queue-based model of the drain block
module tb_nl2_cln_fifo_drain;
    localparam int W = 8;
    logic clk = 0, rst_a = 1, flush_req = 0, flush_busy, flush_done;
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
    logic [15:0] drop_cnt;
`endif
    nl2_cln_fifo_drain_if #(.WIDTH(W)) bus();
    nl2_cln_fifo_drain #(.WIDTH(W)) dut (
        .clk(clk), .rst_a(rst_a), .bus(bus), .flush_req(flush_req),
        .flush_busy(flush_busy), .flush_done(flush_done)
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [W-1:0] fifo_q[$], exp_q[$], got_q[$];
    int got_cyc[$];
    int cyc = 0, pops = 0, flush_pops = 0, busy_cyc = 0, done_cnt = 0, max_cnt = 0;
    int first_pop = -1, flush_cyc = -1, done_cyc = -1, mode = 0;
    int exp_drop = 0;
    logic pop_s = 0, m_ev, m_ep, m_xf;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic refresh();
        bus.fifo_head_valid = fifo_q.size() != 0;
        bus.fifo_head_data = fifo_q.size() != 0 ? fifo_q[0] : '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_s = 0;
            refresh();
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        fifo_q.push_back(v);
        refresh();
    endtask

    task automatic clr_log();
        got_q.delete(); got_cyc.delete();
        pops = 0; flush_pops = 0; busy_cyc = 0; done_cnt = 0; max_cnt = 0;
        first_pop = -1; flush_cyc = -1; done_cyc = -1;
    endtask

    // model: mode 0 streams, 1 discards until head_valid drops, 2 is the completion cycle
    always @(negedge clk) begin
        cyc++;
        if (rst_a) begin
            chk("rst_pop", bus.pop, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_busy", flush_busy, 0);
            chk("rst_done", flush_done, 0);
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
            chk("rst_drop", drop_cnt, 0);
`endif
            mode = 0; exp_q.delete(); exp_drop = 0; pop_s = 0;
        end else begin
            m_ev = mode == 0 && exp_q.size() != 0;
            m_ep = bus.fifo_head_valid && (mode == 0 ? exp_q.size() < 2 : mode == 1);
            m_xf = m_ev && bus.out_ready;
            chk("pop", bus.pop, m_ep);
            chk("out_valid", bus.out_valid, m_ev);
            if (m_ev) chk("out_data", bus.out_data, exp_q[0]);
            chk("flush_busy", flush_busy, mode == 1);
            chk("flush_done", flush_done, mode == 2);
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
            chk("drop_cnt", drop_cnt, exp_drop);
`endif
            if (m_ep) begin pops++; if (first_pop < 0) first_pop = cyc; end
            if (mode == 1 && m_ep) flush_pops++;
            if (mode == 1) busy_cyc++;
            if (mode == 2) begin done_cnt++; done_cyc = cyc; end
            if (m_xf) begin
                got_q.push_back(bus.out_data);
                got_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (mode == 0) begin
                if (flush_req) begin
                    exp_drop = exp_q.size() + (m_ep ? 1 : 0);
                    exp_q.delete();
                    mode = 1;
                    flush_cyc = cyc;
                end else if (m_ep) exp_q.push_back(bus.fifo_head_data);
            end else if (mode == 1) begin
                if (m_ep && exp_drop < 65535) exp_drop++;
                if (!bus.fifo_head_valid) mode = 2;
            end else mode = 0;
            if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
            pop_s = bus.pop;
        end
    end

    initial begin
        bus.out_ready = 0;
        refresh();
        tick(2);
        rst_a = 0;
        // streaming
        clr_log();
        bus.out_ready = 1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        tick(14);
        chk("t1_beats", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk("t1_data", got_q[i], i + 1);
            chk("t1_cyc", got_cyc[i], got_cyc[0] + i);
        end
        chk("t1_pops", pops, 8);
        if (got_cyc.size() != 0) chk("t1_latency", got_cyc[0], first_pop + 1);
        chk("t1_maxcnt", max_cnt, 1);
        // back-pressure
        clr_log();
        bus.out_ready = 0;
        for (int i = 1; i <= 5; i++) push(W'(i));
        tick(6);
        chk("t2_pops", pops, 2);
        chk("t2_hold_valid", bus.out_valid, 1);
        chk("t2_hold_data", bus.out_data, 1);
        chk("t2_fifo_left", fifo_q.size(), 3);
        bus.out_ready = 1;
        tick(10);
        chk("t2_beats", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t2_data", got_q[i], i + 1);
        for (int i = 1; i < got_q.size(); i++) chk("t2_gap", got_cyc[i] - got_cyc[i-1] <= 2, 1);
        // toggling ready
        clr_log();
        for (int i = 1; i <= 8; i++) push(W'(i));
        for (int i = 0; i < 24; i++) begin
            bus.out_ready = (i % 2) == 0;
            tick(1);
        end
        chk("t3_beats", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t3_data", got_q[i], i + 1);
        // flush with full buffer
        clr_log();
        bus.out_ready = 0;
        push(8'h11); push(8'h12);
        tick(3);
        chk("t4_pre_valid", bus.out_valid, 1);
        chk("t4_pre_data", bus.out_data, 8'h11);
        push(8'h21); push(8'h22); push(8'h23);
        flush_req = 1;
        tick(1);
        flush_req = 0;
        chk("t4_valid_drop", bus.out_valid, 0);
        chk("t4_busy", flush_busy, 1);
        tick(8);
        chk("t4_flush_pops", flush_pops, 3);
        chk("t4_busy_cyc", busy_cyc, 4);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_cyc", done_cyc, flush_cyc + 5);
        chk("t4_beats", got_q.size(), 0);
        chk("t4_fifo_empty", fifo_q.size(), 0);
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
        chk("t4_drop", drop_cnt, 5);
`endif
        // flush on empty
        clr_log();
        flush_req = 1;
        tick(1);
        flush_req = 0;
        tick(4);
        chk("t5_pops", pops, 0);
        chk("t5_busy_cyc", busy_cyc, 1);
        chk("t5_done_cnt", done_cnt, 1);
`ifdef NL2_CLN_FIFO_DRAIN_CNT_EN
        chk("t5_drop", drop_cnt, 0);
`endif
        // reset mid-flush
        clr_log();
        for (int i = 0; i < 5; i++) push(W'(8'h31 + i));
        flush_req = 1;
        tick(1);
        flush_req = 0;
        tick(1);
        chk("t6_in_flush", flush_busy, 1);
        rst_a = 1;
        #1;
        chk("t6_rst_pop", bus.pop, 0);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_busy", flush_busy, 0);
        chk("t6_rst_done", flush_done, 0);
        fifo_q.delete();
        refresh();
        tick(2);
        rst_a = 0;
        tick(3);
        chk("t6_no_done", done_cnt, 0);
        bus.out_ready = 1;
        push(8'h0A);
        tick(4);
        chk("t6_beats", got_q.size(), 1);
        if (got_q.size() != 0) chk("t6_data", got_q[0], 8'h0A);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nl2_cln_fifo_drain.md
Name: nl2_cln_fifo_drain

Overview:
- Read-side companion of the shift-register head-valid FIFO (push/pop interface, head entry at index 0).
- Pops the FIFO head and presents the data on a registered valid/ready output channel through a 2-entry skid buffer, so that pop never depends combinationally on out_ready.
- Provides a flush sequence that discards all FIFO and buffered entries, then reports completion with a one-cycle pulse.

Parameters:
- WIDTH, 1, data width; must match the WIDTH of the attached FIFO.

Ports:
- clk  input  1  clock, rising edge.
- rst_a  input  1  asynchronous, active-high reset.
- fifo_head_valid  input  1  FIFO head entry valid.
- fifo_head_data  input  WIDTH  FIFO head entry data.
- pop  output  1  pops the FIFO head this cycle.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  output beat data.
- out_ready  input  1  downstream accepts the beat.
- flush_req  input  1  level request to flush; sampled only in state RUN.
- flush_busy  output  1  high while in state FLUSH.
- flush_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: state=RUN, skid count=0, both buffer entries=0, out_valid=0, out_data=0, flush_busy=0, flush_done=0, pop=0.
- Buffer: 2-entry in-order queue. Entry0 drives out_data; out_valid = (count!=0) in RUN. count is a registered 2-bit value, range 0..2.
- RUN, pop rule: pop = fifo_head_valid & (count<2). pop is a function of registered state and fifo_head_valid only; it never depends on out_ready.
- RUN, accept: a transfer occurs when out_valid & out_ready. Next count = count + pop - transfer.
  - Popped data is written at index (count - transfer).
  - On transfer, entry1 shifts into entry0.
- RUN, simultaneous pop and transfer at count=1: entry0 takes fifo_head_data directly; count stays 1.
- Throughput: 1 beat/cycle in steady state with out_ready=1.
- Latency: head valid in cycle N with count<2 -> pop in N -> out_valid in N+1.
- RUN, back-pressure: with out_ready=0, count fills to 2 and pop stops.
  - out_valid/out_data stay stable until accepted.
  - No entry is lost or duplicated.
- Transitions:
  - RUN with flush_req=1 -> FLUSH. In the same edge, count clears to 0; buffered entries are discarded even if out_valid was high. This is the only permitted withdrawal of out_valid.
  - A transfer in the same cycle as the flush_req sample is still a completed transfer.
  - FLUSH: out_valid=0, flush_busy=1, pop = fifo_head_valid.
  - FLUSH with fifo_head_valid=0 -> DONE (the popped entry on the final valid cycle is discarded).
  - DONE: flush_done=1 for exactly one cycle, pop=0, out_valid=0, then -> RUN.
  - flush_req is ignored in FLUSH and DONE. If flush_req is still high on return to RUN, a new flush starts.
- Entries pushed into the FIFO during FLUSH are also discarded, as long as they arrive before the first cycle with head_valid=0.
- Reset mid-operation: all state returns to reset values asynchronously. A flush in progress is abandoned without a flush_done pulse.
- Illegal state encodings -> RUN with count=0.

Optional Feature:
- Macro: NL2_CLN_FIFO_DRAIN_CNT_EN.
- Defined:
  - Adds output drop_cnt (16 bits), reset to 0.
  - Increments by the number of discarded entries: buffered entries cleared on RUN->FLUSH (0..2), plus 1 per FLUSH-state pop.
  - Saturates at 16'hFFFF.
  - Cleared on the cycle flush_req is sampled in RUN, before the new counts are added.
- Undefined: the drop_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Streaming: FIFO preloaded with 0x1..0x8, out_ready=1 -> pop high 8 consecutive cycles; out_data 0x1..0x8 on consecutive cycles, first beat 1 cycle after the first pop; count never exceeds 1.
- Back-pressure: out_ready=0 with 5 entries queued -> exactly 2 pops, out_data holds 0x1. Then out_ready=1 -> 0x1..0x5 in order, no gaps beyond 1 cycle, no duplicates.
- Toggling ready: out_ready pattern 1,0,1,0 over 8 entries -> all 8 beats delivered in order; pop is never asserted while count=2.
- Flush with full buffer: count=2, FIFO holds 3 entries, flush_req pulsed -> out_valid drops the next cycle, 3 pops, flush_done one cycle later; with the macro defined, drop_cnt=5.
- Flush on empty: count=0, FIFO empty, flush_req=1 for 1 cycle -> FLUSH for 1 cycle, then flush_done pulse, then RUN; no pop.
- Reset mid-flush: rst_a asserted during FLUSH -> state RUN, all outputs 0, no flush_done pulse. After release, new FIFO data 0xA streams out normally.
